// File: rtl/fp32_operand_framer.sv
// fp32_operand_framer: packs 12 UART bytes into a 96-bit {acc, bravo, alpha} frame on a valid/ready port.
module fp32_operand_framer #(
   parameter int TIMEOUT_CYCLES = 13020
) (
   input  logic        CLK_I,
   input  logic        RSTL_I,
   input  logic        BYTE_VALID_I,
   input  logic [7:0]  BYTE_DATA_I,
   output logic        FRAME_VALID_O,
   input  logic        FRAME_READY_I,
   output logic [95:0] FRAME_DATA_O,
   output logic        OVERRUN_O,
   output logic        TIMEOUT_O
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_PENDING} state_t;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [95:0]   asm_q, asm_d, asm_ins;
   logic [95:0]   out_q, out_d;
   logic          vld_q, vld_d;
   logic          ovr_q, ovr_d;
   logic          tpls_q, tpls_d;
   logic          slot_free;
   always_comb begin
      slot_free = !vld_q || FRAME_READY_I;
      asm_ins   = asm_q;
      asm_ins[{cnt_q, 3'b000} +: 8] = BYTE_DATA_I;
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      asm_d     = asm_q;
      out_d     = out_q;
      vld_d     = vld_q && !FRAME_READY_I;
      ovr_d     = 1'b0;
      tpls_d    = 1'b0;
      case (state_q)
         ST_PENDING: begin
            // a byte here is dropped even if the slot frees this cycle
            ovr_d = BYTE_VALID_I;
            if (slot_free) begin
               out_d   = asm_q;
               vld_d   = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (BYTE_VALID_I && cnt_q == 4'd11) begin
               if (slot_free) begin
                  out_d   = asm_ins;
                  vld_d   = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = ST_IDLE;
               end else begin
                  asm_d   = asm_ins;
                  state_d = ST_PENDING;
               end
            end else if (BYTE_VALID_I) begin
               asm_d   = asm_ins;
               cnt_d   = cnt_q + 4'd1;
               tmo_d   = '0;
               state_d = ST_COLLECT;
            end else if (state_q == ST_COLLECT) begin
               if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  cnt_d   = 4'd0;
                  tmo_d   = '0;
                  tpls_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
         end
      endcase
   end
   always_ff @(posedge CLK_I) begin
      if (RSTL_I) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         tmo_q   <= '0;
         asm_q   <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
         tpls_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         asm_q   <= asm_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
         tpls_q  <= tpls_d;
      end
   end
   assign FRAME_VALID_O = vld_q;
   assign FRAME_DATA_O  = out_q;
   assign OVERRUN_O     = ovr_q;
   assign TIMEOUT_O     = tpls_q;
endmodule

// File: tb/tb_fp32_operand_framer.sv
// tb_fp32_operand_framer: directed vectors with a frame scoreboard checked by an independent monitor.
module tb_fp32_operand_framer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        frame_valid;
   logic        frame_ready = 1'b0;
   logic [95:0] frame_data;
   logic        overrun;
   logic        timeout;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_ovr = 0;
   int          n_tmo = 0;
   logic [95:0] exp_q[$];
   fp32_operand_framer #(.TIMEOUT_CYCLES(16)) dut (
      .CLK_I(clk),
      .RSTL_I(rst),
      .BYTE_VALID_I(byte_valid),
      .BYTE_DATA_I(byte_data),
      .FRAME_VALID_O(frame_valid),
      .FRAME_READY_I(frame_ready),
      .FRAME_DATA_O(frame_data),
      .OVERRUN_O(overrun),
      .TIMEOUT_O(timeout)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         if (overrun) n_ovr++;
         if (timeout) n_tmo++;
         if (frame_valid && frame_ready) begin
            if (exp_q.size() == 0) check("unexpected_frame", frame_data, 96'hx);
            else check("frame_data", frame_data, exp_q.pop_front());
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
   endtask
   task automatic send_n(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) send(base + 8'(i));
   endtask
   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", 96'(frame_valid), 96'd0);
      check("rst_data", frame_data, 96'd0);
      check("rst_overrun", 96'(overrun), 96'd0);
      check("rst_timeout", 96'(timeout), 96'd0);
      // basic frame, ready held high
      frame_ready = 1'b1;
      exp_q.push_back(96'h0B0A09080706050403020100);
      send_n(8'h00, 12);
      check("t1_valid_rise", 96'(frame_valid), 96'd1);
      tick();
      check("t1_valid_fall", 96'(frame_valid), 96'd0);
      // backpressure, pending, overrun
      frame_ready = 1'b0;
      send_n(8'h10, 12);
      send_n(8'h20, 12);
      check("t2_hold_valid", 96'(frame_valid), 96'd1);
      check("t2_hold_data", frame_data, 96'h1B1A19181716151413121110);
      send(8'hEE);
      check("t2_overrun_hi", 96'(overrun), 96'd1);
      tick();
      check("t2_overrun_lo", 96'(overrun), 96'd0);
      exp_q.push_back(96'h1B1A19181716151413121110);
      exp_q.push_back(96'h2B2A29282726252423222120);
      frame_ready = 1'b1;
      tick();
      check("t2_b_valid", 96'(frame_valid), 96'd1);
      tick();
      check("t2_b_done", 96'(frame_valid), 96'd0);
      // timeout after 16 idle cycles
      send_n(8'h30, 5);
      for (int i = 0; i < 15; i++) tick();
      check("t3_no_early_timeout", 96'(timeout), 96'd0);
      tick();
      check("t3_timeout_hi", 96'(timeout), 96'd1);
      tick();
      check("t3_timeout_lo", 96'(timeout), 96'd0);
      exp_q.push_back(96'h4B4A49484746454443424140);
      send_n(8'h40, 12);
      check("t3_clean_valid", 96'(frame_valid), 96'd1);
      tick();
      // byte on the 16th idle cycle beats the timeout
      send_n(8'h50, 5);
      for (int i = 0; i < 15; i++) tick();
      exp_q.push_back(96'h5B5A59585756555453525150);
      send_n(8'h55, 7);
      check("t4_valid", 96'(frame_valid), 96'd1);
      tick();
      check("t4_tmo_count", 96'(n_tmo), 96'd1);
      // 12th byte of B lands on A's consuming edge
      frame_ready = 1'b0;
      send_n(8'h60, 12);
      send_n(8'h70, 11);
      exp_q.push_back(96'h6B6A69686766656463626160);
      exp_q.push_back(96'h7B7A79787776757473727170);
      frame_ready = 1'b1;
      send(8'h7B);
      check("t5_valid_stays", 96'(frame_valid), 96'd1);
      check("t5_data_b", frame_data, 96'h7B7A79787776757473727170);
      tick();
      check("t5_valid_fall", 96'(frame_valid), 96'd0);
      check("t5_ovr_count", 96'(n_ovr), 96'd1);
      // reset while a frame is held and another is half built
      frame_ready = 1'b0;
      send_n(8'h80, 12);
      send_n(8'h90, 7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_valid", 96'(frame_valid), 96'd0);
      check("t6_rst_data", frame_data, 96'd0);
      frame_ready = 1'b1;
      exp_q.push_back(96'hABAAA9A8A7A6A5A4A3A2A1A0);
      send_n(8'hA0, 12);
      check("t6_valid", 96'(frame_valid), 96'd1);
      tick();
      tick();
      check("queue_drained", 96'(exp_q.size()), 96'd0);
      check("final_ovr_count", 96'(n_ovr), 96'd1);
      check("final_tmo_count", 96'(n_tmo), 96'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fp32_operand_framer.md
# fp32_operand_framer

Byte-to-frame assembler between the UART byte receiver and the FP32 MAC. Collects 12 consecutive received bytes into one 96-bit operand frame {acc, bravo, alpha} and presents it on a valid/ready interface to the MAC. Holds one complete frame while a second frame is being assembled. Discards partial frames after an inter-byte timeout, so a lost byte cannot misalign later frames.

## Interface
- TIMEOUT_CYCLES, 13020, number of consecutive byte-free cycles in COLLECT after which a partial frame is discarded; legal range ≥ 2.
- CLK_I  in  1  single clock; all logic on rising edge.
- RSTL_I  in  1  synchronous, active-high reset (1 = reset).
- BYTE_VALID_I  in  1  one-cycle strobe, BYTE_DATA_I valid; source cannot be stalled.
- BYTE_DATA_I  in  8  received byte.
- FRAME_VALID_O  out  1  FRAME_DATA_O holds a complete frame.
- FRAME_READY_I  in  1  consumer (MAC) accepts frame when high together with FRAME_VALID_O.
- FRAME_DATA_O  out  96  [31:0] alpha, [63:32] bravo, [95:64] acc.
- OVERRUN_O  out  1  one-cycle pulse, byte dropped.
- TIMEOUT_O  out  1  one-cycle pulse, partial frame discarded.

## Operation
- Storage: assembly register (96 b), byte counter cnt (0..11), timeout counter, output register + FRAME_VALID_O.
- Byte order little-endian: byte k is written to bits [8k+7:8k] (byte 0 = alpha LSB, byte 11 = acc MSB).
- States:
  - IDLE (cnt = 0).
  - COLLECT (1 ≤ cnt ≤ 11).
  - PENDING (12 bytes held, output slot occupied).
- Slot free means !FRAME_VALID_O, or FRAME_VALID_O && FRAME_READY_I in the same cycle.
- IDLE/COLLECT, byte with cnt < 11: store byte, cnt+1, clear timeout counter, go to/stay in COLLECT.
- Byte with cnt = 11 (12th byte):
  - Slot free: load output register with the full frame including this byte, set FRAME_VALID_O, cnt = 0, go to IDLE.
  - Slot not free: store byte, go to PENDING.
- PENDING: when slot free, move assembly to output, set FRAME_VALID_O, go to IDLE. A byte arriving in PENDING is dropped and OVERRUN_O pulses; this holds even if the slot frees in that cycle.
- Timeout counter:
  - Runs only in COLLECT; increments each cycle with BYTE_VALID_I = 0.
  - When it equals TIMEOUT_CYCLES-1 and BYTE_VALID_I = 0: discard partial frame, cnt = 0, counter = 0, go to IDLE, TIMEOUT_O pulses.
  - A byte in that same cycle wins: the byte is stored and there is no timeout.
- Handshake: when FRAME_VALID_O && FRAME_READY_I, the frame is consumed at that edge. FRAME_VALID_O drops unless a new frame loads at the same edge, in which case it stays high with new data.
- FRAME_DATA_O is stable while FRAME_VALID_O && !FRAME_READY_I.
- Assembly register contents are not cleared on discard; only cnt matters.

## Timing
- Reset: FRAME_VALID_O = 0, FRAME_DATA_O = 0, OVERRUN_O = 0, TIMEOUT_O = 0, state IDLE, cnt = 0, timeout counter = 0.
- Reset asserted mid-frame or while FRAME_VALID_O is high: everything returns to reset values at the next edge, and the held frame is lost.
- Latency: FRAME_VALID_O rises in the cycle after the 12th byte's strobe, if the slot is free.
- PENDING to output: frame visible the cycle after the slot frees.
- FRAME_VALID_O is never combinationally dependent on FRAME_READY_I.
- Throughput: one frame per 12 byte strobes; back-to-back strobes on consecutive cycles are accepted.
- Timeout: TIMEOUT_O high in the cycle after the TIMEOUT_CYCLES-th consecutive idle cycle following the last byte.

## Test plan
- Bytes 0x00..0x0B, FRAME_READY_I = 1 -> FRAME_VALID_O for 1 cycle, one cycle after the last byte, FRAME_DATA_O = 0x0B0A09080706050403020100.
- Frame A accepted with READY = 0, then 12 bytes of frame B -> B stays in PENDING. One further byte -> OVERRUN_O pulses once. READY = 1 -> A consumed, B presented the next cycle, and the dropped byte is absent from B.
- 5 bytes, then silence with TIMEOUT_CYCLES = 16 -> TIMEOUT_O pulses after 16 idle cycles. A following clean 12-byte frame assembles correctly, with no stale bytes.
- 5 bytes, then the 6th byte on exactly the 16th idle cycle -> no TIMEOUT_O; frame completes normally after 6 more bytes.
- 12th byte of frame B arrives in the same cycle that READY consumes frame A -> FRAME_VALID_O stays high and FRAME_DATA_O switches to B next cycle; no PENDING, no overrun.
- RSTL_I = 1 for 1 cycle after byte 7 while frame A is held -> FRAME_VALID_O = 0 next cycle. A full 12-byte frame then yields a correct frame.
